// File: rtl/wb_writeback_arbiter_if.sv
// Bus bundle between the writeback arbiter and its neighbours: ALU result
// path, load issue/return path, decode hazard query and the register-file
// write port.
interface wb_writeback_arbiter_if #(
  parameter int DATA_W     = 8,
  parameter int PTR_W      = 4,
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  // ALU result path
  logic              alu_valid;
  logic [PTR_W-1:0]  alu_dst;
  logic [DATA_W-1:0] alu_data;

  // Load issue and return path
  logic              ld_issue;
  logic [PTR_W-1:0]  ld_issue_dst;
  logic              ld_ret_valid;
  logic              ld_ret_ready;
  logic [PTR_W-1:0]  ld_ret_dst;
  logic [DATA_W-1:0] ld_ret_data;

  // Decode hazard query
  logic [PTR_W-1:0]  D_src_0;
  logic [PTR_W-1:0]  D_src_1;
  logic [PTR_W-1:0]  D_src_2;
  logic [PTR_W-1:0]  D_dst;
  logic              D_uses_dst;
  logic              D_hazard;

  // Register-file write port and status
  logic              W_we;
  logic [PTR_W-1:0]  MW_insn_dst;
  logic [DATA_W-1:0] W_result;
  logic [CW-1:0]     fifo_count;
  logic              protocol_err;

  // Arbiter side
  modport slave (
    input  alu_valid, alu_dst, alu_data,
    input  ld_issue, ld_issue_dst,
    input  ld_ret_valid, ld_ret_dst, ld_ret_data,
    output ld_ret_ready,
    input  D_src_0, D_src_1, D_src_2, D_dst, D_uses_dst,
    output D_hazard,
    output W_we, MW_insn_dst, W_result, fifo_count, protocol_err
  );

  // Producer / consumer side
  modport master (
    output alu_valid, alu_dst, alu_data,
    output ld_issue, ld_issue_dst,
    output ld_ret_valid, ld_ret_dst, ld_ret_data,
    input  ld_ret_ready,
    output D_src_0, D_src_1, D_src_2, D_dst, D_uses_dst,
    input  D_hazard,
    input  W_we, MW_insn_dst, W_result, fifo_count, protocol_err
  );
endinterface

// File: rtl/wb_writeback_arbiter.sv
// Writeback arbiter: sole driver of the register-file write port. ALU results
// always win; load returns wait in a small FIFO and drain when the ALU is
// idle. A per-register pending-load scoreboard feeds the decode stall signal,
// and a sticky flag records protocol violations.
module wb_writeback_arbiter #(
  parameter int DATA_W     = 8,
  parameter int REG_CNT    = 16,
  parameter int PTR_W      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset_WB_n,
  wb_writeback_arbiter_if.slave   bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  // Load-return buffer
  logic [PTR_W-1:0]  mem_dst_q  [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_data_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;

  // Write port registers
  logic              we_q, we_d;
  logic [PTR_W-1:0]  dst_q, dst_d;
  logic [DATA_W-1:0] data_q, data_d;

  // Scoreboard and error flag
  logic [REG_CNT-1:0] pend_q, pend_d;
  logic               err_q, err_d;

  logic ready_s;
  logic push_s;
  logic pop_s;
  logic fifo_empty_s;
  logic [PTR_W-1:0]  head_dst_s;
  logic [DATA_W-1:0] head_data_s;

  // Ready comes from the registered count only, so a same-cycle pop never
  // opens a slot for a same-cycle push.
  always_comb begin
    ready_s      = (count_q < DEPTH_C);
    fifo_empty_s = (count_q == {CW{1'b0}});
    push_s       = bus.ld_ret_valid & ready_s;
    pop_s        = ~bus.alu_valid & ~fifo_empty_s;
    head_dst_s   = mem_dst_q[rd_ptr_q];
    head_data_s  = mem_data_q[rd_ptr_q];
  end

  // FIFO pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Write-port selection: ALU first, then FIFO head, otherwise hold dst/data
  always_comb begin
    we_d   = 1'b0;
    dst_d  = dst_q;
    data_d = data_q;
    if (bus.alu_valid) begin
      we_d   = 1'b1;
      dst_d  = bus.alu_dst;
      data_d = bus.alu_data;
    end else if (pop_s) begin
      we_d   = 1'b1;
      dst_d  = head_dst_s;
      data_d = head_data_s;
    end else begin
      we_d   = 1'b0;
    end
  end

  // Scoreboard update (issue set overrides pop clear) and error detection
  always_comb begin
    pend_d = pend_q;
    if (pop_s) begin
      pend_d[head_dst_s] = 1'b0;
    end else begin
      pend_d = pend_q;
    end
    if (bus.ld_issue) begin
      pend_d[bus.ld_issue_dst] = 1'b1;
    end else begin
      pend_d[bus.ld_issue_dst] = pend_d[bus.ld_issue_dst];
    end
    err_d = err_q
          | (bus.ld_issue  & pend_q[bus.ld_issue_dst])
          | (push_s        & ~pend_q[bus.ld_ret_dst])
          | (bus.alu_valid & pend_q[bus.alu_dst]);
  end

  // Control and write-port state registers
  always_ff @(posedge clk or negedge reset_WB_n) begin
    if (!reset_WB_n) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
      we_q     <= 1'b0;
      dst_q    <= {PTR_W{1'b0}};
      data_q   <= {DATA_W{1'b0}};
      pend_q   <= {REG_CNT{1'b0}};
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      we_q     <= we_d;
      dst_q    <= dst_d;
      data_q   <= data_d;
      pend_q   <= pend_d;
      err_q    <= err_d;
    end
  end

  // FIFO storage, written at the tail on each accepted return
  always_ff @(posedge clk or negedge reset_WB_n) begin
    if (!reset_WB_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_dst_q[i]  <= {PTR_W{1'b0}};
        mem_data_q[i] <= {DATA_W{1'b0}};
      end
    end else if (push_s) begin
      mem_dst_q[wr_ptr_q]  <= bus.ld_ret_dst;
      mem_data_q[wr_ptr_q] <= bus.ld_ret_data;
    end
  end

  // Output mapping; hazard is combinational against the registered scoreboard
  assign bus.ld_ret_ready = ready_s;
  assign bus.D_hazard     = pend_q[bus.D_src_0] | pend_q[bus.D_src_1] |
                            pend_q[bus.D_src_2] |
                            (bus.D_uses_dst & pend_q[bus.D_dst]);
  assign bus.W_we         = we_q;
  assign bus.MW_insn_dst  = dst_q;
  assign bus.W_result     = data_q;
  assign bus.fifo_count   = count_q;
  assign bus.protocol_err = err_q;

endmodule

// File: tb/tb_wb_writeback_arbiter.sv
// Directed bench for wb_writeback_arbiter: ALU writes, load return path,
// FIFO back-pressure, scoreboard set/clear collision, sticky error,
// asynchronous reset and pointer wrap.
module tb_wb_writeback_arbiter;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  int   idx;
  int   last_idx;
  logic acc;
  logic [3:0] wdst [$];
  logic [7:0] wdat [$];

  wb_writeback_arbiter_if #(.DATA_W(8), .PTR_W(4), .FIFO_DEPTH(4)) bus ();

  wb_writeback_arbiter #(
    .DATA_W(8), .REG_CNT(16), .PTR_W(4), .FIFO_DEPTH(4)
  ) dut (
    .clk       (clk),
    .reset_WB_n(rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ret(input int i, input logic [7:0] base);
    bus.ld_ret_valid = 1'b1;
    bus.ld_ret_dst   = 4'(i);
    bus.ld_ret_data  = base + 8'(i);
  endtask

  // One cycle of the return producer; holds data until the handshake lands.
  task automatic ret_step(input logic [7:0] base, input logic record);
    acc = bus.ld_ret_valid & bus.ld_ret_ready;
    tick();
    if (record && bus.W_we) begin
      wdst.push_back(bus.MW_insn_dst);
      wdat.push_back(bus.W_result);
    end
    if (acc) begin
      idx++;
      if (idx <= last_idx) set_ret(idx, base);
      else bus.ld_ret_valid = 1'b0;
    end
  endtask

  task automatic issue(input int d);
    bus.ld_issue     = 1'b1;
    bus.ld_issue_dst = 4'(d);
    tick();
    bus.ld_issue     = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    bus.alu_valid = 1'b0; bus.alu_dst = 4'd0; bus.alu_data = 8'd0;
    bus.ld_issue = 1'b0; bus.ld_issue_dst = 4'd0;
    bus.ld_ret_valid = 1'b0; bus.ld_ret_dst = 4'd0; bus.ld_ret_data = 8'd0;
    bus.D_src_0 = 4'd0; bus.D_src_1 = 4'd0; bus.D_src_2 = 4'd0;
    bus.D_dst = 4'd0; bus.D_uses_dst = 1'b0;
    rst_n = 1'b0;
    #1;
    // Reset values
    chk("rst_we",    32'(bus.W_we), 32'd0);
    chk("rst_dst",   32'(bus.MW_insn_dst), 32'd0);
    chk("rst_data",  32'(bus.W_result), 32'd0);
    chk("rst_cnt",   32'(bus.fifo_count), 32'd0);
    chk("rst_ready", 32'(bus.ld_ret_ready), 32'd1);
    chk("rst_err",   32'(bus.protocol_err), 32'd0);
    chk("rst_haz",   32'(bus.D_hazard), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();

    // ALU write appears one edge later, then we drops with dst/data held
    bus.alu_valid = 1'b1; bus.alu_dst = 4'd3; bus.alu_data = 8'h5A;
    tick();
    bus.alu_valid = 1'b0;
    chk("alu_we",   32'(bus.W_we), 32'd1);
    chk("alu_dst",  32'(bus.MW_insn_dst), 32'd3);
    chk("alu_data", 32'(bus.W_result), 32'h5A);
    tick();
    chk("alu_we_off",  32'(bus.W_we), 32'd0);
    chk("alu_dst_hold", 32'(bus.MW_insn_dst), 32'd3);
    chk("alu_data_hold", 32'(bus.W_result), 32'h5A);

    // Single load: hazard while pending, write one edge after acceptance
    bus.D_src_1 = 4'd7;
    issue(7);
    chk("ld7_haz", 32'(bus.D_hazard), 32'd1);
    set_ret(7, 8'h2C);            // 0x2C + 7 = 0x33
    tick();
    bus.ld_ret_valid = 1'b0;
    chk("ld7_we_early", 32'(bus.W_we), 32'd0);
    chk("ld7_cnt", 32'(bus.fifo_count), 32'd1);
    chk("ld7_haz_still", 32'(bus.D_hazard), 32'd1);
    tick();
    chk("ld7_we",   32'(bus.W_we), 32'd1);
    chk("ld7_dst",  32'(bus.MW_insn_dst), 32'd7);
    chk("ld7_data", 32'(bus.W_result), 32'h33);
    chk("ld7_haz_clr", 32'(bus.D_hazard), 32'd0);
    chk("ld7_cnt0", 32'(bus.fifo_count), 32'd0);
    bus.D_src_1 = 4'd0;

    // Back-pressure: ALU busy for 6 cycles, returns to 1..5
    for (int i = 1; i <= 5; i++) issue(i);
    bus.alu_valid = 1'b1; bus.alu_dst = 4'd0; bus.alu_data = 8'hE0;
    idx = 1; last_idx = 5;
    set_ret(1, 8'hA0);
    for (int c = 0; c < 6; c++) ret_step(8'hA0, 1'b0);
    chk("bp_accepted", 32'(idx), 32'd5);
    chk("bp_cnt4",   32'(bus.fifo_count), 32'd4);
    chk("bp_ready0", 32'(bus.ld_ret_ready), 32'd0);
    chk("bp_hold",   32'(bus.ld_ret_valid), 32'd1);
    chk("bp_alu_dst", 32'(bus.MW_insn_dst), 32'd0);
    bus.alu_valid = 1'b0;
    wdst.delete(); wdat.delete();
    for (int c = 0; c < 6; c++) begin
      ret_step(8'hA0, 1'b1);
      if (c == 0) begin
        chk("bp_pop1_cnt",   32'(bus.fifo_count), 32'd3);
        chk("bp_pop1_ready", 32'(bus.ld_ret_ready), 32'd1);
      end
    end
    chk("bp_nwrites", 32'(wdst.size()), 32'd5);
    for (int k = 0; k < 5; k++) begin
      chk("bp_order_dst",  32'(wdst[k]), 32'(k + 1));
      chk("bp_order_data", 32'(wdat[k]), 32'(8'hA1 + 8'(k)));
    end
    chk("bp_cnt_end", 32'(bus.fifo_count), 32'd0);
    bus.D_src_0 = 4'd1; bus.D_src_1 = 4'd2; bus.D_src_2 = 4'd3;
    bus.D_dst = 4'd5; bus.D_uses_dst = 1'b1;
    #1;
    chk("bp_haz_clear", 32'(bus.D_hazard), 32'd0);
    chk("bp_err0", 32'(bus.protocol_err), 32'd0);

    // Return to a non-pending register flags a sticky error
    set_ret(2, 8'h20);
    tick();
    bus.ld_ret_valid = 1'b0;
    chk("err_set", 32'(bus.protocol_err), 32'd1);
    repeat (3) tick();
    chk("err_sticky", 32'(bus.protocol_err), 32'd1);

    // Issue and pop to the same register in one cycle: set wins
    bus.D_src_0 = 4'd0; bus.D_src_1 = 4'd0; bus.D_src_2 = 4'd9;
    bus.D_uses_dst = 1'b0;
    set_ret(9, 8'h90);            // 0x99, not pending
    tick();
    bus.ld_ret_valid = 1'b0;
    chk("col_cnt", 32'(bus.fifo_count), 32'd1);
    chk("col_haz_pre", 32'(bus.D_hazard), 32'd0);
    issue(9);                     // pop of old dst 9 happens in this cycle
    chk("col_we",   32'(bus.W_we), 32'd1);
    chk("col_dst",  32'(bus.MW_insn_dst), 32'd9);
    chk("col_data", 32'(bus.W_result), 32'h99);
    chk("col_haz",  32'(bus.D_hazard), 32'd1);
    tick();
    chk("col_haz_keep", 32'(bus.D_hazard), 32'd1);

    // Asynchronous reset with three buffered loads and pending bits
    for (int i = 1; i <= 3; i++) issue(i);
    bus.alu_valid = 1'b1; bus.alu_dst = 4'd0; bus.alu_data = 8'h77;
    idx = 1; last_idx = 3;
    set_ret(1, 8'hC0);
    for (int c = 0; c < 3; c++) ret_step(8'hC0, 1'b0);
    chk("ar_cnt3",  32'(bus.fifo_count), 32'd3);
    chk("ar_we_pre", 32'(bus.W_we), 32'd1);
    chk("ar_data_pre", 32'(bus.W_result), 32'h77);
    bus.alu_valid = 1'b0;
    bus.D_src_0 = 4'd1; bus.D_src_1 = 4'd2; bus.D_src_2 = 4'd9;
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_we",    32'(bus.W_we), 32'd0);
    chk("ar_dst",   32'(bus.MW_insn_dst), 32'd0);
    chk("ar_data",  32'(bus.W_result), 32'd0);
    chk("ar_cnt",   32'(bus.fifo_count), 32'd0);
    chk("ar_ready", 32'(bus.ld_ret_ready), 32'd1);
    chk("ar_err",   32'(bus.protocol_err), 32'd0);
    chk("ar_haz",   32'(bus.D_hazard), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("ar_no_stale_we", 32'(bus.W_we), 32'd0);
      chk("ar_cnt_post",    32'(bus.fifo_count), 32'd0);
    end

    // Pointer wrap: 10 back-to-back returns with the ALU idle
    for (int i = 1; i <= 10; i++) issue(i);
    idx = 1; last_idx = 10;
    set_ret(1, 8'h40);
    wdst.delete(); wdat.delete();
    for (int c = 0; c < 12; c++) begin
      ret_step(8'h40, 1'b1);
      chk("wrap_cnt_le1", 32'(bus.fifo_count <= 3'd1), 32'd1);
    end
    chk("wrap_nwrites", 32'(wdst.size()), 32'd10);
    for (int k = 0; k < 10; k++) begin
      chk("wrap_dst",  32'(wdst[k]), 32'(k + 1));
      chk("wrap_data", 32'(wdat[k]), 32'(8'h41 + 8'(k)));
    end
    chk("wrap_err0", 32'(bus.protocol_err), 32'd0);
    chk("wrap_haz0", 32'(bus.D_hazard), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
